thermostat_request_gen: RTL and testbench

//  Upstream stage of the heating controller FSM. Turns a stream of temperature

---
 rtl/thermostat_request_gen.sv | 206 ++++++++++++++++++++
 tb/tb_thermostat_request_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/thermostat_request_gen.sv
// thermostat_request_gen
//   Upstream stage of the heating controller FSM. Converts temperature samples
//   and a setpoint into mutually exclusive heat/cool requests, with hysteresis,
//   a minimum dwell per request and an idle gap after every request so the
//   controller never sees both requests high nor a direct heat<->cool flip.
//
// Ports
//   clock       in        single clock, all logic on posedge
//   rst         in        synchronous active-high reset
//   enable      in        0 forces IDLE and clears all timing
//   temp_valid  in        temp/setpoint carry an accepted sample this cycle
//   temp        in  [TW]  temperature sample, LSB = 0.1 degC
//   setpoint    in  [TW]  target temperature, sampled with each accepted sample
//   heat_req    out       registered heat request (controller input A)
//   cool_req    out       registered cool request (controller input B)
//   dwell_busy  out       registered, high while dwell or gap timing is running
//
// Build option
//   THERM_SAMPLE_FILTER_EN : decisions use the truncated mean of the last four
//   accepted samples, wait for four samples after reset/enable drop, and add
//   one cycle of latency. Undefined: decisions use temp directly.

module thermostat_request_gen #(
  parameter int unsigned TW        = 10,
  parameter int unsigned HYST      = 4,
  parameter int unsigned MIN_DWELL = 8,
  parameter int unsigned IDLE_GAP  = 2
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          enable,
  input  logic          temp_valid,
  input  logic [TW-1:0] temp,
  input  logic [TW-1:0] setpoint,
  output logic          heat_req,
  output logic          cool_req,
  output logic          dwell_busy
);

  localparam int unsigned DW = $clog2(MIN_DWELL + 1);
  localparam int unsigned GW = $clog2(IDLE_GAP + 1);

  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [GW-1:0] GAP_MAX   = GW'(IDLE_GAP);
  localparam logic [TW:0]   HYST_EXT  = (TW+1)'(HYST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [DW-1:0] dwell_r;
  logic [DW-1:0] dwell_nxt_s;
  logic [DW-1:0] dwell_inc_s;
  logic [GW-1:0] gap_r;
  logic [GW-1:0] gap_nxt_s;
  logic [GW-1:0] gap_inc_s;

  // Effective temperature, effective setpoint and "take a decision" strobe.
  logic [TW-1:0] t_s;
  logic [TW-1:0] sp_s;
  logic          decide_s;

`ifdef THERM_SAMPLE_FILTER_EN
  logic [TW-1:0] tap0_r, tap1_r, tap2_r, tap3_r;
  logic [2:0]    fill_r;
  logic          fvalid_r;
  logic [TW-1:0] sp_r;
  logic [TW+1:0] sum_s;

  // Four-deep sample history; clears with reset or enable drop.
  always_ff @(posedge clock) begin
    if (rst || !enable) begin
      tap0_r   <= '0;
      tap1_r   <= '0;
      tap2_r   <= '0;
      tap3_r   <= '0;
      fill_r   <= 3'd0;
      fvalid_r <= 1'b0;
      sp_r     <= '0;
    end else if (temp_valid) begin
      tap0_r   <= temp;
      tap1_r   <= tap0_r;
      tap2_r   <= tap1_r;
      tap3_r   <= tap2_r;
      fill_r   <= (fill_r == 3'd4) ? fill_r : fill_r + 3'd1;
      fvalid_r <= 1'b1;
      sp_r     <= setpoint;
    end else begin
      fvalid_r <= 1'b0;
    end
  end

  assign sum_s    = {2'b00, tap0_r} + {2'b00, tap1_r} + {2'b00, tap2_r} + {2'b00, tap3_r};
  assign t_s      = sum_s[TW+1:2];
  assign sp_s     = sp_r;
  // The sample that fills the history is the first one allowed to decide.
  assign decide_s = fvalid_r && (fill_r == 3'd4);
`else
  assign t_s      = temp;
  assign sp_s     = setpoint;
  assign decide_s = temp_valid;
`endif

  // One extra bit so t+HYST and setpoint+HYST never wrap.
  logic [TW:0] t_ext_s;
  logic [TW:0] sp_ext_s;
  logic        want_heat_s;
  logic        want_cool_s;

  assign t_ext_s     = {1'b0, t_s};
  assign sp_ext_s    = {1'b0, sp_s};
  assign want_heat_s = (t_ext_s + HYST_EXT) < sp_ext_s;
  assign want_cool_s = t_ext_s > (sp_ext_s + HYST_EXT);
  assign dwell_inc_s = (dwell_r == DWELL_MAX) ? dwell_r : dwell_r + DW'(1'b1);
  assign gap_inc_s   = gap_r + GW'(1'b1);

  // Next-state decision; only accepted samples advance, enable=0 overrides all.
  always_comb begin
    state_nxt_s = state_r;
    dwell_nxt_s = dwell_r;
    gap_nxt_s   = gap_r;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
      dwell_nxt_s = '0;
      gap_nxt_s   = '0;
    end else if (decide_s) begin
      case (state_r)
        ST_IDLE: begin
          // The entry sample counts as the first dwell sample.
          if (want_heat_s) begin
            state_nxt_s = ST_HEAT;
            dwell_nxt_s = DW'(1'b1);
            gap_nxt_s   = '0;
          end else if (want_cool_s) begin
            state_nxt_s = ST_COOL;
            dwell_nxt_s = DW'(1'b1);
            gap_nxt_s   = '0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HEAT: begin
          if ((t_ext_s >= sp_ext_s) && (dwell_inc_s == DWELL_MAX)) begin
            state_nxt_s = ST_HOLD;
            dwell_nxt_s = '0;
            gap_nxt_s   = '0;
          end else begin
            dwell_nxt_s = dwell_inc_s;
          end
        end
        ST_COOL: begin
          if ((t_ext_s <= sp_ext_s) && (dwell_inc_s == DWELL_MAX)) begin
            state_nxt_s = ST_HOLD;
            dwell_nxt_s = '0;
            gap_nxt_s   = '0;
          end else begin
            dwell_nxt_s = dwell_inc_s;
          end
        end
        ST_HOLD: begin
          // Gap samples are only those taken while already in HOLD.
          if (gap_inc_s == GAP_MAX) begin
            state_nxt_s = ST_IDLE;
            dwell_nxt_s = '0;
            gap_nxt_s   = '0;
          end else begin
            gap_nxt_s = gap_inc_s;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          dwell_nxt_s = '0;
          gap_nxt_s   = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, counters and outputs, all registered from the next state.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      dwell_r    <= '0;
      gap_r      <= '0;
      heat_req   <= 1'b0;
      cool_req   <= 1'b0;
      dwell_busy <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      dwell_r    <= dwell_nxt_s;
      gap_r      <= gap_nxt_s;
      heat_req   <= (state_nxt_s == ST_HEAT);
      cool_req   <= (state_nxt_s == ST_COOL);
      dwell_busy <= (((state_nxt_s == ST_HEAT) || (state_nxt_s == ST_COOL)) &&
                     (dwell_nxt_s < DWELL_MAX)) || (state_nxt_s == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_thermostat_request_gen.sv
module tb_thermostat_request_gen;

  logic       clock;
  logic       rst;
  logic       enable;
  logic       temp_valid;
  logic [9:0] temp;
  logic [9:0] setpoint;
  logic       heat_req;
  logic       cool_req;
  logic       dwell_busy;

  int checks;
  int failures;

  thermostat_request_gen #(
    .TW(10), .HYST(4), .MIN_DWELL(8), .IDLE_GAP(2)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .enable     (enable),
    .temp_valid (temp_valid),
    .temp       (temp),
    .setpoint   (setpoint),
    .heat_req   (heat_req),
    .cool_req   (cool_req),
    .dwell_busy (dwell_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One cycle of stimulus with the expected {heat, cool, busy} after the edge.
  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [9:0] t;
    logic [9:0] sp;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[48];
  int   nvec;

  task automatic add(input logic r, input logic e, input logic v,
                     input int t, input int sp, input logic [2:0] exp);
    vecs[nvec].rst = r;
    vecs[nvec].en  = e;
    vecs[nvec].vld = v;
    vecs[nvec].t   = 10'(t);
    vecs[nvec].sp  = 10'(sp);
    vecs[nvec].exp = exp;
    nvec++;
  endtask

  task automatic check3(input string name, input int idx, input logic [2:0] exp);
    logic [2:0] got;
    got = {heat_req, cool_req, dwell_busy};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] {heat,cool,busy} got=%b expected=%b", name, idx, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, sample outputs 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic v,
                      input logic [9:0] t, input logic [9:0] sp);
    @(negedge clock);
    rst        = r;
    enable     = e;
    temp_valid = v;
    temp       = t;
    setpoint   = sp;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    nvec       = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    temp_valid = 1'b0;
    temp       = 10'd0;
    setpoint   = 10'd0;

    // Reset held with random inputs: all outputs low every cycle.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom));
      check3("reset", i, 3'b000);
    end

`ifdef THERM_SAMPLE_FILTER_EN
    // Warm-up: three samples are not enough to decide.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 10'd190, 10'd200);
      check3("filt_warm", i, 3'b000);
    end
    step(1'b0, 1'b1, 1'b1, 10'd190, 10'd200);
    check3("filt_4th_n1", 0, 3'b000);
    step(1'b0, 1'b1, 1'b0, 10'd190, 10'd200);
    check3("filt_4th_n2", 0, 3'b101);
    // Enable drop clears the history; one new sample must not request.
    step(1'b0, 1'b0, 1'b0, 10'd190, 10'd200);
    check3("filt_drop", 0, 3'b000);
    step(1'b0, 1'b1, 1'b1, 10'd190, 10'd200);
    check3("filt_one", 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'd190, 10'd200);
      check3("filt_one_wait", i, 3'b000);
    end
`else
    // Heat entry at the hysteresis edge, dwell, then the idle gap.
    add(0, 1, 1, 196, 200, 3'b000);
    add(0, 1, 1, 195, 200, 3'b101);
    for (int i = 2; i <= 7; i++) add(0, 1, 1, 205, 200, 3'b101);
    add(0, 1, 1, 205, 200, 3'b001);
    add(0, 1, 0, 195, 200, 3'b001);
    add(0, 1, 1, 195, 200, 3'b001);
    add(0, 1, 1, 195, 200, 3'b000);
    // Cool, enable drop, re-entry with the dwell restarted.
    add(0, 1, 1, 205, 200, 3'b011);
    add(0, 1, 1, 205, 200, 3'b011);
    add(0, 0, 1, 205, 200, 3'b000);
    add(0, 1, 1, 205, 200, 3'b011);
    for (int i = 2; i <= 7; i++) add(0, 1, 1, 200, 200, 3'b011);
    add(0, 1, 1, 200, 200, 3'b001);
    add(0, 1, 1, 200, 200, 3'b001);
    add(0, 1, 1, 200, 200, 3'b000);
    // Range boundaries.
    add(0, 1, 1, 1023, 1020, 3'b000);
    add(0, 1, 1, 0,    0,    3'b000);
    add(0, 1, 1, 1019, 1023, 3'b000);
    add(0, 1, 1, 1018, 1023, 3'b101);
    // Dwell saturates while still cold: heat stays, busy drops.
    for (int i = 2; i <= 7; i++) add(0, 1, 1, 0, 1023, 3'b101);
    add(0, 1, 1, 0, 1023, 3'b100);
    add(0, 1, 1, 0, 1023, 3'b100);

    for (int i = 0; i < nvec; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].vld, vecs[i].t, vecs[i].sp);
      check3("vec", i, vecs[i].exp);
    end

    // No accepted samples for 50 cycles: HEAT is held despite a hot input.
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 1'b0, 10'd1023, 10'd0);
      check3("no_valid", i, 3'b100);
    end
    step(1'b0, 1'b1, 1'b1, 10'd1023, 10'd0);
    check3("heat_exit", 0, 3'b001);
    step(1'b0, 1'b1, 1'b1, 10'd1023, 10'd0);
    check3("gap1", 0, 3'b001);
    step(1'b0, 1'b1, 1'b1, 10'd1023, 10'd0);
    check3("gap2", 0, 3'b000);
    step(1'b0, 1'b1, 1'b1, 10'd1023, 10'd0);
    check3("cool_max", 0, 3'b011);
    // Reset mid-request, then idle with no samples.
    step(1'b1, 1'b1, 1'b1, 10'd1023, 10'd0);
    check3("rst_mid", 0, 3'b000);
    step(1'b0, 1'b1, 1'b0, 10'd1023, 10'd0);
    check3("after_rst", 0, 3'b000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
